// File: rtl/ad_dac_tx_sync_framer_if.sv
// Sample datapath bundle for ad_dac_tx_sync_framer: the DMA request/accept
// side (valid strobe, incoming channel words, underflow) and the framed link
// side (outgoing channel words and their update strobe). The framer uses
// the master modport; the DMA/link environment uses the slave modport.
interface ad_dac_tx_sync_framer_if #(
    parameter int NUM_CHANNELS  = 4,
    parameter int CHANNEL_WIDTH = 32
) ();
    logic                                    dac_valid;
    logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   dac_data_in;
    logic                                    dac_dunf;
    logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   dac_data_out;
    logic                                    dac_data_valid_out;

    modport master (
        output dac_valid,
        input  dac_data_in,
        input  dac_dunf,
        output dac_data_out,
        output dac_data_valid_out
    );

    modport slave (
        input  dac_valid,
        output dac_data_in,
        output dac_dunf,
        input  dac_data_out,
        input  dac_data_valid_out
    );
endinterface

// File: rtl/ad_dac_tx_sync_framer.sv
// ad_dac_tx_sync_framer: multi-channel DAC transmit framer (dac_clk domain).
// Arm/sync state machine (master when ID==0, slave otherwise), paced DMA
// sample requests, per-channel enable masking, underflow zero-stuffing and a
// saturating underflow counter.
// Optional feature macro: DAC_SYNC_TIMEOUT_EN -- a slave stuck in ARMED for
// 65535 cycles without a sync edge falls back to IDLE and raises a sticky
// dac_sync_timeout flag. Without it the slave waits indefinitely.
module ad_dac_tx_sync_framer #(
    parameter int NUM_CHANNELS  = 4,
    parameter int CHANNEL_WIDTH = 32,
    parameter int ID            = 0,
    parameter int RATIO_WIDTH   = 4
) (
    input  logic                    dac_clk,
    input  logic                    dac_rstn,
    input  logic                    dac_sync_arm,
    input  logic                    dac_sync_in,
    output logic                    dac_sync_out,
    input  logic [NUM_CHANNELS-1:0] dac_enable,
    input  logic [RATIO_WIDTH-1:0]  dac_ratio,
    input  logic                    dac_unf_clr,
    output logic [1:0]              dac_state,
    output logic [15:0]             dac_unf_count,
    output logic                    dac_sync_timeout,
    ad_dac_tx_sync_framer_if.master tx
);
    localparam int DW = NUM_CHANNELS * CHANNEL_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_RUN   = 2'b10
    } state_t;

    state_t                 r_state;
    logic                   r_sync_out;
    logic [RATIO_WIDTH-1:0] r_cnt;
    logic [RATIO_WIDTH-1:0] r_ratio;
    logic                   r_sync_cur;
    logic                   r_sync_prev;
    logic [DW-1:0]          r_data_out;
    logic                   r_data_valid;
    logic [15:0]            r_unf_cnt;
    logic                   w_sync_edge;
    logic                   w_valid;
    logic                   w_unf;
    logic [DW-1:0]          w_masked;
`ifdef DAC_SYNC_TIMEOUT_EN
    logic [15:0]            r_to_cnt;
    logic                   r_timeout;
`endif

    // Rising edge of the registered sync input (current sample vs previous).
    assign w_sync_edge = r_sync_cur & ~r_sync_prev;
    // One request per ratio period, starting on the first RUN cycle.
    assign w_valid     = (r_state == S_RUN) && (r_cnt == '0);
    assign w_unf       = w_valid & tx.dac_dunf;

    // Sync input is sampled every cycle so a level that rose outside ARMED
    // cannot look like a fresh edge once armed.
    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            r_sync_cur  <= 1'b0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync_cur  <= dac_sync_in;
            r_sync_prev <= r_sync_cur;
        end
    end

    // Arm/sync state machine with the request-period counter.
    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            r_state    <= S_IDLE;
            r_sync_out <= 1'b0;
            r_cnt      <= '0;
            r_ratio    <= '0;
`ifdef DAC_SYNC_TIMEOUT_EN
            r_to_cnt   <= 16'd0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_sync_out <= 1'b0;
`ifdef DAC_SYNC_TIMEOUT_EN
            if (dac_sync_arm) begin
                r_timeout <= 1'b0;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (dac_sync_arm) begin
                        r_state    <= S_ARMED;
                        r_sync_out <= (ID == 0);
`ifdef DAC_SYNC_TIMEOUT_EN
                        r_to_cnt   <= 16'd0;
`endif
                    end
                end
                S_ARMED: begin
                    if ((ID == 0) || w_sync_edge) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_ratio <= dac_ratio;
                    end
`ifdef DAC_SYNC_TIMEOUT_EN
                    else if (r_to_cnt == 16'hFFFE) begin
                        r_state   <= S_IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
`endif
                end
                S_RUN: begin
                    if (dac_sync_arm) begin
                        r_state    <= S_ARMED;
                        r_sync_out <= (ID == 0);
`ifdef DAC_SYNC_TIMEOUT_EN
                        r_to_cnt   <= 16'd0;
`endif
                    end else if (r_cnt == r_ratio) begin
                        // New ratio is only picked up at the wrap point.
                        r_cnt   <= '0;
                        r_ratio <= dac_ratio;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-channel enable mask applied to the incoming sample.
    always_comb begin
        w_masked = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_masked[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
                dac_enable[ch] ? tx.dac_data_in[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH]
                               : {CHANNEL_WIDTH{1'b0}};
        end
    end

    // Sample capture: one-cycle latency, zero-stuffed on underflow, held between requests.
    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else if (w_valid) begin
            r_data_out   <= tx.dac_dunf ? '0 : w_masked;
            r_data_valid <= 1'b1;
        end else begin
            r_data_valid <= 1'b0;
        end
    end

    // Saturating underflow counter; a clear coinciding with an underflow leaves 1.
    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            r_unf_cnt <= 16'd0;
        end else if (dac_unf_clr) begin
            r_unf_cnt <= w_unf ? 16'd1 : 16'd0;
        end else if (w_unf && (r_unf_cnt != 16'hFFFF)) begin
            r_unf_cnt <= r_unf_cnt + 16'd1;
        end
    end

    assign dac_state             = r_state;
    assign dac_sync_out          = r_sync_out;
    assign dac_unf_count         = r_unf_cnt;
    assign tx.dac_valid          = w_valid;
    assign tx.dac_data_out       = r_data_out;
    assign tx.dac_data_valid_out = r_data_valid;
`ifdef DAC_SYNC_TIMEOUT_EN
    assign dac_sync_timeout      = r_timeout;
`else
    assign dac_sync_timeout      = 1'b0;
`endif
endmodule

// File: doc/ad_dac_tx_sync_framer.md
Name: ad_dac_tx_sync_framer

Overview:
Parametrised multi-channel DAC transmit framer. It replaces fixed 4-channel, always-valid TX datapaths with configurable channel count, sample width and DMA request rate. It adds an arm/sync state machine (master or slave), per-channel enables, underflow zero-stuffing and an underflow counter. It sits between the DMA/DDS sources and the JESD/LVDS DAC link, in the dac_clk domain.

Parameters:
NUM_CHANNELS, 4, number of DAC channels (I/Q counted separately), 1..16
CHANNEL_WIDTH, 32, bits per channel per dac_clk
ID, 0, 0 = sync master (generates dac_sync_out); nonzero = slave (follows dac_sync_in)
RATIO_WIDTH, 4, width of dac_ratio

Ports:
dac_clk  in  1  DAC-side clock
dac_rstn  in  1  reset, asynchronous, active-low
dac_sync_arm  in  1  one-cycle pulse from register bank; arms/re-arms sync
dac_sync_in  in  1  sync from master instance (slave only)
dac_sync_out  out  1  one-cycle sync pulse (master only)
dac_enable  in  NUM_CHANNELS  per-channel enable
dac_ratio  in  RATIO_WIDTH  request period minus one (0 = every cycle)
dac_valid  out  1  sample request/accept strobe to DMA
dac_data_in  in  NUM_CHANNELS*CHANNEL_WIDTH  channel data, ch0 in LSBs
dac_dunf  in  1  DMA underflow, qualified by dac_valid
dac_unf_clr  in  1  clears underflow counter
dac_data_out  out  NUM_CHANNELS*CHANNEL_WIDTH  framed data to link
dac_data_valid_out  out  1  dac_data_out updated this cycle
dac_state  out  2  00 IDLE, 01 ARMED, 10 RUN
dac_unf_count  out  16  saturating underflow count
dac_sync_timeout  out  1  sticky slave sync timeout flag

Behaviour:
- Reset (async, dac_rstn=0): state IDLE. All outputs 0, including dac_data_out, counters and the sync_in edge register.
- IDLE: dac_valid=0, data_out held at 0. dac_sync_arm moves to ARMED.
- ARMED, master (ID==0): dac_sync_out=1 for exactly the first ARMED cycle. Next cycle goes to RUN. Arm pulses while ARMED are ignored.
- ARMED, slave: registers dac_sync_in. A rising edge (current=1, previous=0) moves to RUN next cycle. Edges in IDLE/RUN are ignored. Master ignores dac_sync_in.
- RUN: dac_sync_arm returns to ARMED (resync). Output data holds its last value; no new dac_valid until RUN is re-entered.
- Request counter, in RUN only: resets to 0 on RUN entry and counts 0..dac_ratio, wrapping. dac_valid = (state==RUN && cnt==0), so the first valid is on the first RUN cycle. A dac_ratio change takes effect at the next wrap.
- Capture: on a dac_valid cycle, the next cycle gives dac_data_out[ch] = dac_enable[ch] ? dac_data_in[ch] : 0, with dac_data_valid_out=1. Latency is 1 cycle.
- Between valids, dac_data_out holds and dac_data_valid_out=0.
- Underflow: dac_valid && dac_dunf gives an all-zero sample regardless of enables, and dac_unf_count +1, saturating at 0xFFFF.
- dac_unf_clr sets the count to 0. Simultaneous clr and underflow gives 1.
- dac_enable sampled only on valid cycles; mid-RUN changes apply to the next sample.
- Async reset mid-RUN: immediate return to IDLE with outputs zeroed. Re-arm is required.

Optional Feature:
DAC_SYNC_TIMEOUT_EN
- Defined: a slave in ARMED counts cycles with a 16-bit counter cleared on ARMED entry. At 65535 without an edge, it returns to IDLE and sets dac_sync_timeout (sticky). The flag clears on the next dac_sync_arm or reset. The master is unaffected.
- Not defined: no counter; slave waits in ARMED indefinitely; dac_sync_timeout tied 0.

Test Plan:
- Master, NUM_CHANNELS=4, ratio=0:
  - Stimulus: arm pulse at cycle 10.
  - Required: sync_out=1 at cycle 11, state=RUN at 12, dac_valid=1 every cycle from 12, data_out = data_in delayed 1 cycle.
- Slave, ratio=3:
  - Stimulus: arm, then sync_in rises 20 cycles later.
  - Required: state stays ARMED until the edge, RUN 2 cycles after the raw edge, dac_valid every 4th cycle.
  - Also: sync_in edge while IDLE produces no state change.
- Enables=4'b0101, data_in ch words 0x11111111/0x22222222/0x33333333/0x44444444:
  - Required: data_out = {0, 0x33333333, 0, 0x11111111}.
- Underflow, ratio=1:
  - Stimulus: assert dac_dunf on 3 valid cycles and 1 non-valid cycle.
  - Required: 3 zero samples, dac_unf_count=3.
  - Counter preloaded to 0xFFFF stays 0xFFFF on underflow.
  - Clr with simultaneous underflow gives 1.
- Reset and re-arm:
  - Stimulus: dac_rstn low mid-RUN between clock edges.
  - Required: outputs 0 and state IDLE immediately.
  - Arm pulse in RUN gives ARMED, then RUN, with the counter restarting at 0.
- With DAC_SYNC_TIMEOUT_EN, slave with no sync_in:
  - Required: IDLE after 65535 ARMED cycles, timeout=1, cleared by the next arm.
  - Edge at cycle 65534 gives RUN with timeout=0.
